// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation controller.
// Controller state encoding and default operand width.
package sar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sar_state_t;

    localparam int SAR_N_DEFAULT = 4;

endpackage

// File: rtl/sar_ctrl.sv
// SAR controller: drives comparator B operand, resolves A MSB first.
// Define SAR_SETTLE_EN to add a settle cycle before each bit decision.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int N = SAR_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         ge,
    output logic [N-1:0] trial,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int IW = $clog2(N);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_CONV = CONV;
    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    logic [0:0]    state;
    logic [IW-1:0] idx;
    logic [N-1:0]  dec;
    logic          last;
    logic          decide;

`ifdef SAR_SETTLE_EN
    logic phase;
    assign decide = phase;
`else
    assign decide = 1'b1;
`endif

    assign last = (idx == '0);

    // Trial code after resolving bit idx and arming the next lower bit.
    always_comb begin
        dec = trial;
        if (!ge) begin
            dec[idx] = 1'b0;
        end
        if (!last) begin
            dec[idx - IW'(1)] = 1'b1;
        end
    end

    // Conversion sequencer: start capture, per-bit decisions, completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
`ifdef SAR_SETTLE_EN
            phase  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                (state == ST_IDLE): begin
                    if (start) begin
                        trial <= MSB;
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= ST_CONV;
`ifdef SAR_SETTLE_EN
                        phase <= 1'b0;
`endif
                    end
                end
                (state == ST_CONV): begin
`ifdef SAR_SETTLE_EN
                    phase <= ~phase;
`endif
                    if (decide) begin
                        if (last) begin
                            result <= dec;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            trial  <= '0;
                            state  <= ST_IDLE;
                        end else begin
                            trial <= dec;
                            idx   <= idx - IW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal A >= B comparator model.
// Covers N=4 and N=8 instances; honours SAR_SETTLE_EN timing.
module tb_sar_ctrl;

`ifdef SAR_SETTLE_EN
    localparam int EPB = 2;
`else
    localparam int EPB = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic       ge4;
    logic [3:0] trial4;
    logic       busy4;
    logic       done4;
    logic [3:0] result4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic       ge8;
    logic [7:0] trial8;
    logic       busy8;
    logic       done8;
    logic [7:0] result8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ge4 = (a4 >= trial4);
    assign ge8 = (a8 >= trial8);

    sar_ctrl #(.N(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .ge     (ge4),
        .trial  (trial4),
        .busy   (busy4),
        .done   (done4),
        .result (result4)
    );

    sar_ctrl #(.N(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .ge     (ge8),
        .trial  (trial8),
        .busy   (busy8),
        .done   (done8),
        .result (result8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // seq packs the four expected trial codes, first in the top nibble.
    task automatic conv4(input logic [3:0] a, input logic [15:0] seq,
                         input logic [3:0] res);
        a4 = a;
        start4 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < EPB; p++) begin
                @(negedge clk);
                start4 = 1'b0;
                check("trial4", 32'(trial4), 32'(seq[15 - 4*b -: 4]));
                check("busy4", 32'(busy4), 32'd1);
                check("done4_lo", 32'(done4), 32'd0);
            end
        end
        @(negedge clk);
        check("done4", 32'(done4), 32'd1);
        check("result4", 32'(result4), 32'(res));
        check("busy4_end", 32'(busy4), 32'd0);
        check("trial4_end", 32'(trial4), 32'd0);
        @(negedge clk);
        check("done4_pulse", 32'(done4), 32'd0);
        check("result4_hold", 32'(result4), 32'(res));
    endtask

    task automatic conv8(input logic [7:0] a, input logic [7:0] res);
        a8 = a;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("trial8_msb", 32'(trial8), 32'h80);
        for (int i = 1; i < 8 * EPB; i++) begin
            @(negedge clk);
            check("done8_lo", 32'(done8), 32'd0);
        end
        @(negedge clk);
        check("done8", 32'(done8), 32'd1);
        check("result8", 32'(result8), 32'(res));
        check("busy8_end", 32'(busy8), 32'd0);
    endtask

    initial begin
        int dones;
        int hold;

        #2;
        check("rst_trial", 32'(trial4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_result", 32'(result4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        conv4(4'd9, 16'h8CA9, 4'd9);
        conv4(4'd0, 16'h8421, 4'd0);
        conv4(4'd15, 16'h8CEF, 4'd15);

        // start held high: two back-to-back conversions, busy starts ignored
        a4 = 4'd6;
        start4 = 1'b1;
        dones = 0;
        hold = 2 * (4 * EPB + 1);
        for (int i = 0; i < hold + 4 * EPB + 2; i++) begin
            @(negedge clk);
            if (i == hold - 1) start4 = 1'b0;
            if (done4) begin
                dones++;
                check("b2b_result", 32'(result4), 32'd6);
            end
        end
        check("b2b_count", 32'(dones), 32'd2);
        check("b2b_idle", 32'(busy4), 32'd0);

        // reset mid-conversion discards the partial result
        a4 = 4'd12;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (2 * EPB) @(negedge clk);
        check("mid_trial", 32'(trial4), 32'hE);
        rst_n = 1'b0;
        #1;
        check("arst_trial", 32'(trial4), 32'd0);
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_done", 32'(done4), 32'd0);
        check("arst_result", 32'(result4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(trial4), 32'd0);
        conv4(4'd12, 16'h8CED, 4'd12);

        conv8(8'd200, 8'd200);
        conv8(8'd255, 8'd255);
        conv8(8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
